dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 76 +++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory answering one request at a time
// after WAIT_CYCLES wait states, with error flagging and a saturating error count.
module dmem_responder #(
  parameter int ADDR_WORDS_LOG2 = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  err_count
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] CNT_LOAD = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
  state_t state, nxt;
  logic [3:0] cnt;
  logic we_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [2**ADDR_WORDS_LOG2];
  logic accept, handshake, enter_resp, cur_we, cur_err;
  logic [31:0] cur_addr, cur_wdata;
  logic [ADDR_WORDS_LOG2-1:0] idx;
  // With zero wait states RESP is entered on the accepting edge, so use the live request
  always_comb begin
    accept = state == IDLE && req_valid;
    handshake = state == RESP && rsp_ready;
    enter_resp = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
    cur_we = state == IDLE ? req_we : we_q;
    cur_addr = state == IDLE ? req_addr : addr_q;
    cur_wdata = state == IDLE ? req_wdata : wdata_q;
    cur_err = cur_addr[1:0] != 2'b00 || |(cur_addr[31:2] >> ADDR_WORDS_LOG2);
    idx = cur_addr[ADDR_WORDS_LOG2+1:2];
    nxt = enter_resp ? RESP : accept ? WAIT : handshake ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      err_count <= '0;
      busy <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      if (accept) begin
        we_q <= req_we;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        cnt <= CNT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err <= cur_err;
        rsp_rdata <= (cur_err || cur_we) ? '0 : mem[idx];
      end else if (handshake) rsp_valid <= 1'b0;
      if (handshake && rsp_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      state <= nxt;
      busy <= nxt != IDLE;
      req_ready <= nxt == IDLE;
    end
  // Gated by rst_n so a store abandoned by reset never lands
  always_ff @(posedge clk)
    if (rst_n && enter_resp && cur_we && !cur_err) mem[idx] <= cur_wdata;
endmodule
